// File: rtl/icache_bus_pkg.sv
// -----------------------------------------------------------------------------
// icache_bus_pkg
// Shared definitions for the icache read-miss bus: response codes, the
// responder's state encoding, and the burst-length limits.
// No ports (package).
// -----------------------------------------------------------------------------
package icache_bus_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A cached refill is one 4-word line (arlen = LINE_BEATS-1).
  localparam int LINE_BEATS = 4;

  // Largest burst the responder serves from SRAM; longer bursts decode as errors.
  localparam logic [7:0] MAX_ARLEN = 8'd15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/icache_rsp_fifo2.sv
// -----------------------------------------------------------------------------
// icache_rsp_fifo2
// Two-entry registered FIFO for response beats. Storage only; the caller
// handles any bypass from the incoming beat.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   push, push_data  write a beat (ignored when full)
//   pop              drop the head beat (ignored when empty)
//   full, empty      occupancy flags (2 entries / 0 entries)
//   head             oldest stored beat, meaningful when !empty
// -----------------------------------------------------------------------------
module icache_rsp_fifo2 #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] entries [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & (count != 2'd2);
  assign do_pop  = pop & (count != 2'd0);

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Payload storage needs no reset; head is only consumed when !empty.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/icache_rd_responder.sv
// -----------------------------------------------------------------------------
// icache_rd_responder
// Memory-side responder for icache read misses. Accepts one read address,
// reads the instruction SRAM word by word and returns an INCR burst of beats.
// Out-of-window or over-long requests return DECERR beats without touching SRAM.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   i_arvalid/i_arready          request handshake
//   i_araddr, i_arlen            byte address (bits [1:0] ignored), beats-1
//   i_rvalid/i_rready            beat handshake
//   i_rdata, i_rresp, i_rlast    beat payload
//   mem_en, mem_addr, mem_rdata  SRAM read port (data one cycle after mem_en)
// -----------------------------------------------------------------------------
module icache_rd_responder
  import icache_bus_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter int               MEM_AW    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1C00_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_arvalid,
  output logic              i_arready,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  output logic              i_rvalid,
  input  logic              i_rready,
  output logic [DATA_W-1:0] i_rdata,
  output logic [1:0]        i_rresp,
  output logic              i_rlast,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEAT_W = DATA_W + 3;
  localparam logic [ADDR_W-1:0] WINDOW_WORDS = {{(ADDR_W-1){1'b0}}, 1'b1} << MEM_AW;

  state_t state_q, state_d;

  logic              err_q;
  logic              issue_active_q;
  logic [7:0]        issue_cnt_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] last_idx;
  logic              dec_err;
  logic              ar_fire;
  logic              issue;

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] head_beat;
  logic [BEAT_W-1:0] out_beat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              beat_fire;

  // Request decode: the last word of the burst must stay inside the window.
  assign offset   = i_araddr - BASE_ADDR;
  assign last_idx = (offset >> 2) + {{(ADDR_W-8){1'b0}}, i_arlen};
  assign dec_err  = (i_araddr < BASE_ADDR) | (last_idx >= WINDOW_WORDS) |
                    (i_arlen > MAX_ARLEN);

  assign ar_fire = i_arvalid & (state_q == ST_IDLE);

  // At most two beats may be buffered or in flight, so the FIFO never overflows.
  assign issue = (state_q == ST_BURST) & issue_active_q & ~fifo_full &
                 (fifo_empty | ~inflight_q);

  assign mem_en   = issue & ~err_q;
  assign mem_addr = mem_addr_q;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    i_arready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        i_arready = 1'b1;
        if (i_arvalid) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (beat_fire && i_rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The issue counter wraps after the final issue, but issue_active_q blocks reuse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q           <= 1'b0;
      issue_active_q  <= 1'b0;
      issue_cnt_q     <= 8'd0;
      mem_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (ar_fire) begin
        err_q          <= dec_err;
        issue_active_q <= 1'b1;
        issue_cnt_q    <= i_arlen;
        mem_addr_q     <= offset[MEM_AW+1:2];
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q - 8'd1;
        mem_addr_q  <= mem_addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
        if (issue_cnt_q == 8'd0) issue_active_q <= 1'b0;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue & (issue_cnt_q == 8'd0);
    end
  end

  assign in_beat = {(err_q ? {DATA_W{1'b0}} : mem_rdata),
                    (err_q ? RESP_DECERR : RESP_OKAY),
                    inflight_last_q};

  // When the buffer is empty the returning beat is presented directly, which
  // gives first data two cycles after the request handshake.
  assign i_rvalid  = ~fifo_empty | inflight_q;
  assign out_beat  = ~fifo_empty ? head_beat : (inflight_q ? in_beat : '0);
  assign beat_fire = i_rvalid & i_rready;
  assign fifo_pop  = beat_fire & ~fifo_empty;
  assign fifo_push = inflight_q & ~(beat_fire & fifo_empty);

  assign i_rdata = out_beat[BEAT_W-1:3];
  assign i_rresp = out_beat[2:1];
  assign i_rlast = out_beat[0];

  icache_rsp_fifo2 #(
    .W(BEAT_W)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fifo_push),
    .push_data(in_beat),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_beat)
  );

endmodule

// File: tb/tb_icache_rd_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_rd_responder
// Self-checking bench for icache_rd_responder: directed scenarios followed by
// randomized bursts, checked against a burst-level reference model.
// -----------------------------------------------------------------------------
module tb_icache_rd_responder;
  import icache_bus_pkg::*;

  localparam logic [31:0] BASE   = 32'h1C00_0000;
  localparam int          MEM_AW = 14;
  localparam int          WORDS  = 1 << MEM_AW;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rstn;
  logic        i_arvalid;
  logic        i_arready;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic        i_rvalid;
  logic        i_rready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rlast;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata;

  int errors;
  int checks;

  beat_t exp_q[$];
  beat_t prev_b;
  bit    prev_stall;
  bit    busy;
  bit    burst_err;
  bit    seen_first;
  bit    acc_flag;
  int    cyc;
  int    acc_cyc;
  int    last_hs_cyc;
  int    issued;
  int    delivered;
  int    exp_addr;
  int    rr_mode;
  logic [15:0] pat;
  int    pat_len;

  icache_rd_responder dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_arvalid(i_arvalid),
    .i_arready(i_arready),
    .i_araddr (i_araddr),
    .i_arlen  (i_arlen),
    .i_rvalid (i_rvalid),
    .i_rready (i_rready),
    .i_rdata  (i_rdata),
    .i_rresp  (i_rresp),
    .i_rlast  (i_rlast),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
  endfunction

  // Backing SRAM: data one cycle after mem_en, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_val({18'd0, mem_addr});
    else        mem_rdata <= $urandom;
  end

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected beats of a request from the address-map rules.
  task automatic model_accept(input logic [31:0] a, input logic [7:0] len);
    longint unsigned idx;
    bit err;
    beat_t b;
    err = (a < BASE) || (len > 8'd15);
    idx = (longint'(a) - longint'(BASE)) / 4;
    if (!err && (idx + len >= WORDS)) err = 1;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = err ? 32'd0 : mem_val(32'(idx + i));
      b.resp = err ? 2'b11 : 2'b00;
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
    busy       = 1;
    burst_err  = err;
    acc_cyc    = cyc;
    seen_first = 0;
    issued     = 0;
    delivered  = 0;
    exp_addr   = int'(idx);
    acc_flag   = 1;
  endtask

  task automatic run_cycle();
    beat_t b;
    bit busy0;
    int k;
    @(negedge clk);
    cyc++;
    busy0 = busy;
    check_output("arready", i_arready, !busy0);
    if (exp_q.size() == 0) check_output("rvalid_idle", i_rvalid, 0);
    if (prev_stall) begin
      check_output("stall_rvalid", i_rvalid, 1);
      check_output("stall_rdata", i_rdata, prev_b.data);
      check_output("stall_rresp", i_rresp, prev_b.resp);
      check_output("stall_rlast", i_rlast, prev_b.last);
    end
    if (busy0 && burst_err) check_output("mem_en_err", mem_en, 0);
    if (mem_en) begin
      check_output("mem_addr", mem_addr, exp_addr);
      check_output("outstanding", (issued - delivered + 1) <= 2, 1);
      exp_addr++;
      issued++;
    end
    if (busy0 && i_rvalid && !seen_first) begin
      check_output("first_latency", cyc - acc_cyc, 2);
      seen_first = 1;
    end
    if (i_rvalid && i_rready && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      check_output("rdata", i_rdata, b.data);
      check_output("rresp", i_rresp, b.resp);
      check_output("rlast", i_rlast, b.last);
      delivered++;
      if (b.last) begin
        busy        = 0;
        last_hs_cyc = cyc;
      end
    end
    prev_stall  = i_rvalid && !i_rready;
    prev_b.data = i_rdata;
    prev_b.resp = i_rresp;
    prev_b.last = i_rlast;
    if (i_arvalid && !busy0) model_accept(i_araddr, i_arlen);
    @(posedge clk);
    #1;
    case (rr_mode)
      1: begin
        k = cyc + 1 - acc_cyc - 2;
        i_rready = (k < 0 || k >= pat_len) ? 1'b1 : pat[k];
      end
      2: i_rready = ($urandom_range(0, 99) < 70);
      default: i_rready = 1'b1;
    endcase
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [7:0] len);
    int n;
    n = 0;
    i_arvalid = 1'b1;
    i_araddr  = a;
    i_arlen   = len;
    acc_flag  = 0;
    while (!acc_flag && n < 400) begin
      run_cycle();
      n++;
    end
    check_output("accept_timeout", acc_flag, 1);
    i_arvalid = 1'b0;
    i_araddr  = $urandom;
    i_arlen   = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 400) begin
      run_cycle();
      n++;
    end
    check_output("drain_timeout", busy, 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    busy       = 0;
    burst_err  = 0;
    prev_stall = 0;
    issued     = 0;
    delivered  = 0;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_model();
  endtask

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    logic [31:0] a;
    logic [7:0]  len;
    int          acc_a;
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    acc_cyc   = 0;
    rr_mode   = 0;
    pat       = 16'h0;
    pat_len   = 0;
    clk       = 1'b0;
    rstn      = 1'b0;
    i_arvalid = 1'b0;
    i_araddr  = 32'd0;
    i_arlen   = 8'd0;
    i_rready  = 1'b1;
    clear_model();
    do_reset(3);

    // Reset values
    @(negedge clk);
    check_output("rst_arready", i_arready, 1);
    check_output("rst_rvalid", i_rvalid, 0);
    check_output("rst_rlast", i_rlast, 0);
    check_output("rst_rdata", i_rdata, 0);
    check_output("rst_rresp", i_rresp, 0);
    check_output("rst_mem_en", mem_en, 0);
    @(posedge clk);
    #1;

    // Cached line refill, one beat per cycle
    $display("[TB] cached refill");
    apply_stimulus(BASE + 32'h40, 8'(LINE_BEATS - 1));
    drain();
    check_output("refill_last_cycle", last_hs_cyc - acc_cyc, 5);
    run_cycle();

    // Uncached single-word fetch, low address bits ignored
    $display("[TB] uncached fetch");
    apply_stimulus(BASE + 32'h106, 8'd0);
    drain();
    check_output("uncached_last_cycle", last_hs_cyc - acc_cyc, 2);
    run_cycle();

    // Backpressure pattern 1,0,0,1,1,0,1
    $display("[TB] backpressure");
    rr_mode = 1;
    pat     = 16'h0059;
    pat_len = 7;
    apply_stimulus(BASE + 32'h200, 8'd3);
    drain();
    rr_mode = 0;
    run_cycle();

    // Decode errors and the window boundary
    $display("[TB] decode errors");
    apply_stimulus(BASE - 32'd4, 8'd3);
    drain();
    apply_stimulus(BASE + 32'((WORDS - 2) * 4), 8'd3);
    drain();
    apply_stimulus(BASE + 32'((WORDS - 4) * 4), 8'd3);
    drain();
    apply_stimulus(BASE + 32'h80, 8'd16);
    drain();
    run_cycle();

    // Reset after the second beat of four
    $display("[TB] reset mid-burst");
    apply_stimulus(BASE + 32'h300, 8'd3);
    begin
      int n;
      n = 0;
      while (delivered < 2 && n < 50) begin
        run_cycle();
        n++;
      end
      check_output("mid_burst_progress", delivered, 2);
    end
    do_reset(1);
    @(negedge clk);
    check_output("post_rst_rvalid", i_rvalid, 0);
    check_output("post_rst_arready", i_arready, 1);
    @(posedge clk);
    #1;
    apply_stimulus(BASE + 32'h340, 8'd3);
    drain();
    run_cycle();

    // Back-to-back: second request waits for the last handshake
    $display("[TB] back-to-back");
    apply_stimulus(BASE + 32'h400, 8'd3);
    acc_a = acc_cyc;
    apply_stimulus(BASE + 32'h800, 8'd1);
    check_output("b2b_first_last", last_hs_cyc - acc_a, 5);
    check_output("b2b_accept", acc_cyc - last_hs_cyc, 1);
    drain();
    run_cycle();

    // Randomized bursts with random backpressure
    $display("[TB] random bursts");
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: a = BASE - 32'($urandom_range(1, 100) * 4);
        1: a = BASE + 32'((WORDS - int'($urandom_range(1, 20))) * 4) + 32'($urandom_range(0, 3));
        default: a = BASE + 32'($urandom_range(0, WORDS - 1) * 4) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 9) == 0) len = 8'($urandom_range(16, 20));
      else                           len = 8'($urandom_range(0, 15));
      apply_stimulus(a, len);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    rr_mode = 0;
    run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
